// File: rtl/vga_pkg.sv
// vga_pkg -- shared types and constants for the pixel prefetch path.
//   rgb332_t       : one pixel, r[7:5] g[4:2] b[1:0]
//   fetch_state_t  : framebuffer fetch FSM states (IDLE, REQ, DONE)
//   H_ACTIVE, V_ACTIVE, PIX_PER_WORD : visible frame geometry and packing
//   FRAME_WORDS_DEFAULT : 32-bit words in one 640x480 RGB332 frame
package vga_pkg;

  localparam int H_ACTIVE            = 640;
  localparam int V_ACTIVE            = 480;
  localparam int PIX_PER_WORD        = 4;
  localparam int FRAME_WORDS_DEFAULT = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with a combinational head word.
// Parameters: WIDTH (word width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset (empties the FIFO)
//   flush  : synchronous empty, takes priority over push/pop
//   push   : write wdata (accepted when not full, or when popping too)
//   wdata  : write data
//   pop    : drop the head word (ignored when empty)
//   rdata  : current head word
//   full   : DEPTH words stored
//   empty  : no words stored
//   count  : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + {{(AW-1){1'b0}}, 1'b1};
      if (do_push && !do_pop)      count_reg <= count_reg + {{AW{1'b0}}, 1'b1};
      else if (do_pop && !do_push) count_reg <= count_reg - {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wdata;
  end

  assign rdata = mem_reg[rd_ptr_reg];
  // DEPTH is a power of two, so the count MSB alone marks "full".
  assign full  = count_reg[AW];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/pixel_prefetch_fifo.sv
// pixel_prefetch_fifo -- prefetches framebuffer words into a FIFO and hands
// them out one RGB332 pixel at a time (big-endian byte order in each word).
// Optional build macro: PIXEL_PREFETCH_STATS_EN adds the underrun_cnt port.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   frame_start       : one-cycle pulse; flush FIFO and refetch from BASE_ADDR
//   pix_req           : consumer takes one pixel this cycle
//   pix_data          : head pixel (8'h00 when nothing is buffered)
//   pix_valid         : a buffered pixel is available
//   underrun          : sticky, pix_req seen while pix_valid was low
//   mem_addr, mem_rd  : word read request (address held until mem_ack)
//   mem_ack, mem_rdata: read completion and data
//   underrun_cnt      : (stats build only) saturating underrun counter
module pixel_prefetch_fifo
  import vga_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pix_req,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic        underrun,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef PIXEL_PREFETCH_STATS_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int             AW        = $clog2(DEPTH);
  localparam int             CW        = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0]  FRAME_C   = CW'(FRAME_WORDS);
  localparam logic [CW-1:0]  LAST_WORD = CW'(FRAME_WORDS - 1);
  localparam logic [AW:0]    DEPTH_C   = {1'b1, {AW{1'b0}}};

  fetch_state_t  state_reg, state_next;
  logic [31:0]   addr_reg;
  logic [CW-1:0] words_reg;
  logic [1:0]    byte_idx_reg;
  logic          underrun_reg;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic [AW:0]   fifo_count;
  logic          ack_taken, take_pix, miss;
  logic [7:0]    lane [PIX_PER_WORD];
  rgb332_t       pix_sel;

  // frame_start wins over any coincident ack or consumer request.
  assign ack_taken = (state_reg == REQ) && mem_ack && !frame_start;
  assign take_pix  = pix_req && pix_valid && !frame_start;
  assign miss      = pix_req && !pix_valid && !frame_start;
  // Only one read is ever outstanding and it is only issued with room left,
  // so the full gate never blocks a legitimate push.
  assign fifo_push = ack_taken && !fifo_full;
  assign fifo_pop  = take_pix && (byte_idx_reg == 2'd3);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (frame_start),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    mem_rd     = 1'b0;
    unique case (state_reg)
      IDLE: if ((words_reg < FRAME_C) && (fifo_count < DEPTH_C)) state_next = REQ;
      REQ: begin
        mem_rd = 1'b1;
        if (ack_taken) state_next = (words_reg == LAST_WORD) ? DONE : IDLE;
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (frame_start) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      addr_reg     <= BASE_ADDR;
      words_reg    <= '0;
      byte_idx_reg <= 2'd0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (frame_start) begin
        addr_reg     <= BASE_ADDR;
        words_reg    <= '0;
        byte_idx_reg <= 2'd0;
        underrun_reg <= 1'b0;
      end else begin
        if (ack_taken) begin
          addr_reg  <= addr_reg + 32'd4;
          words_reg <= words_reg + CW'(1);
        end
        // Two-bit index wraps 3 -> 0 exactly when the head word is popped.
        if (take_pix) byte_idx_reg <= byte_idx_reg + 2'd1;
        if (miss)     underrun_reg <= 1'b1;
      end
    end
  end

`ifdef PIXEL_PREFETCH_STATS_EN
  logic [15:0] underrun_cnt_reg;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underrun_cnt_reg <= 16'h0000;
    end else if (frame_start) begin
      underrun_cnt_reg <= 16'h0000;
    end else if (miss && (underrun_cnt_reg != 16'hFFFF)) begin
      underrun_cnt_reg <= underrun_cnt_reg + 16'h0001;
    end
  end
  assign underrun_cnt = underrun_cnt_reg;
`endif

  // Byte lane 0 is the most significant byte of the head word.
  generate
    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
      assign lane[gi] = fifo_head[31 - 8*gi -: 8];
    end
  endgenerate

  assign pix_sel   = rgb332_t'(lane[byte_idx_reg]);
  assign pix_valid = !fifo_empty;
  assign pix_data  = pix_valid ? pix_sel : 8'h00;
  assign underrun  = underrun_reg;
  assign mem_addr  = addr_reg;

endmodule

// File: tb/tb_pixel_prefetch_fifo.sv
// tb_pixel_prefetch_fifo -- directed bench for pixel_prefetch_fifo.
// A table of per-cycle vectors covers the first fetches after frame_start;
// hand-written sequences cover underrun, flush during a request, FIFO fill
// and refill, reset during a request, and a 3-word frame on a second instance.
module tb_pixel_prefetch_fifo;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start, pix_req;
  logic [7:0]  pix_data;
  logic        pix_valid, underrun;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_ack;
  logic [31:0] mem_rdata;
`ifdef PIXEL_PREFETCH_STATS_EN
  logic [15:0] underrun_cnt;
  logic [15:0] underrun_cnt3;
`endif

  logic        fs3, req3;
  logic [7:0]  data3;
  logic        valid3, und3, rd3, ack3;
  logic [31:0] addr3, rdata3;

  logic mem_en, ack_force;
  int   lat;
  int   wait_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] data_for(input logic [31:0] a);
    logic [31:0] k;
    k = (a - BASE) >> 2;
    if (k == 32'd0) return 32'hE01C_03FF;
    return {8'h10 + k[7:0], 8'h20 + k[7:0], 8'h30 + k[7:0], 8'h40 + k[7:0]};
  endfunction

  // Memory model: acks once the request has waited 'lat' cycles.
  always @(posedge clock) begin
    if (!mem_rd || mem_ack) wait_cnt <= 0;
    else                    wait_cnt <= wait_cnt + 1;
  end
  assign mem_ack   = ack_force | (mem_rd & mem_en & (wait_cnt >= lat));
  assign mem_rdata = data_for(mem_addr);

  assign ack3   = rd3;
  assign rdata3 = data_for(addr3);

  pixel_prefetch_fifo dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underrun    (underrun),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef PIXEL_PREFETCH_STATS_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  pixel_prefetch_fifo #(.FRAME_WORDS(3)) dut3 (
    .clock       (clock),
    .reset       (reset),
    .frame_start (fs3),
    .pix_req     (req3),
    .pix_data    (data3),
    .pix_valid   (valid3),
    .underrun    (und3),
    .mem_addr    (addr3),
    .mem_rd      (rd3),
    .mem_ack     (ack3),
    .mem_rdata   (rdata3)
`ifdef PIXEL_PREFETCH_STATS_EN
    ,
    .underrun_cnt(underrun_cnt3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fs;
    logic        req;
    logic        rd;
    logic [31:0] addr;
    logic        valid;
    logic [7:0]  data;
    logic        und;
  } vec_t;

  vec_t vecs [12];

  task automatic set_vec(input int i, input logic fs, input logic req, input logic rd,
                         input logic [31:0] addr, input logic valid, input logic [7:0] data,
                         input logic und);
    vecs[i].fs = fs; vecs[i].req = req; vecs[i].rd = rd; vecs[i].addr = addr;
    vecs[i].valid = valid; vecs[i].data = data; vecs[i].und = und;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp3 [12];
    int reads, pix_n, lat_seen;
    logic found;

    //        cyc fs    req   rd    addr           valid data   und
    set_vec(0,  1'b1, 1'b1, 1'b0, 32'h4000_0000, 1'b0, 8'h00, 1'b0);
    set_vec(1,  1'b0, 1'b1, 1'b0, 32'h4000_0000, 1'b0, 8'h00, 1'b0);
    set_vec(2,  1'b0, 1'b1, 1'b1, 32'h4000_0000, 1'b0, 8'h00, 1'b1);
    set_vec(3,  1'b0, 1'b1, 1'b0, 32'h4000_0004, 1'b1, 8'hE0, 1'b1);
    set_vec(4,  1'b0, 1'b1, 1'b1, 32'h4000_0004, 1'b1, 8'h1C, 1'b1);
    set_vec(5,  1'b0, 1'b1, 1'b0, 32'h4000_0008, 1'b1, 8'h03, 1'b1);
    set_vec(6,  1'b0, 1'b1, 1'b1, 32'h4000_0008, 1'b1, 8'hFF, 1'b1);
    set_vec(7,  1'b0, 1'b1, 1'b0, 32'h4000_000C, 1'b1, 8'h11, 1'b1);
    set_vec(8,  1'b0, 1'b1, 1'b1, 32'h4000_000C, 1'b1, 8'h21, 1'b1);
    set_vec(9,  1'b0, 1'b1, 1'b0, 32'h4000_0010, 1'b1, 8'h31, 1'b1);
    set_vec(10, 1'b0, 1'b1, 1'b1, 32'h4000_0010, 1'b1, 8'h41, 1'b1);
    set_vec(11, 1'b0, 1'b0, 1'b0, 32'h4000_0014, 1'b1, 8'h12, 1'b1);

    exp3 = '{8'hE0, 8'h1C, 8'h03, 8'hFF, 8'h11, 8'h21, 8'h31, 8'h41,
             8'h12, 8'h22, 8'h32, 8'h42};

    reset = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
    fs3 = 1'b0; req3 = 1'b0;
    mem_en = 1'b1; ack_force = 1'b0; lat = 0;

    // ---- reset state ----
    repeat (3) @(negedge clock);
    #1;
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_pix_data", {24'd0, pix_data}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    $display("reset: rd=%0b addr=%h valid=%0b data=%h", mem_rd, mem_addr, pix_valid, pix_data);

    // ---- table: frame_start then continuous consumption ----
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      frame_start = vecs[i].fs;
      pix_req     = vecs[i].req;
      #1;
      $display("vec %0d fs=%0b req=%0b rd=%0b addr=%h valid=%0b data=%h underrun=%0b",
               i, frame_start, pix_req, mem_rd, mem_addr, pix_valid, pix_data, underrun);
      check($sformatf("vec%0d_rd", i), {31'd0, mem_rd}, {31'd0, vecs[i].rd});
      check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("vec%0d_valid", i), {31'd0, pix_valid}, {31'd0, vecs[i].valid});
      check($sformatf("vec%0d_data", i), {24'd0, pix_data}, {24'd0, vecs[i].data});
      check($sformatf("vec%0d_underrun", i), {31'd0, underrun}, {31'd0, vecs[i].und});
      @(negedge clock);
    end
`ifdef PIXEL_PREFETCH_STATS_EN
    #1 check("vec_underrun_cnt", {16'd0, underrun_cnt}, 32'd2);
`endif

    // ---- underrun before any data, cleared by frame_start ----
    pix_req = 1'b0; mem_en = 1'b0; frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0; pix_req = 1'b1;
    #1;
    check("udr_pre_valid", {31'd0, pix_valid}, 32'd0);
    check("udr_pre_flag", {31'd0, underrun}, 32'd0);
    @(negedge clock);
    pix_req = 1'b0;
    #1;
    $display("underrun: flag=%0b data=%h", underrun, pix_data);
    check("udr_flag", {31'd0, underrun}, 32'd1);
    check("udr_data", {24'd0, pix_data}, 32'd0);
`ifdef PIXEL_PREFETCH_STATS_EN
    check("udr_cnt", {16'd0, underrun_cnt}, 32'd1);
`endif
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    #1;
    check("udr_cleared", {31'd0, underrun}, 32'd0);
`ifdef PIXEL_PREFETCH_STATS_EN
    check("udr_cnt_cleared", {16'd0, underrun_cnt}, 32'd0);
`endif

    // ---- frame_start coinciding with mem_ack during a request ----
    @(negedge clock);
    #1 check("flush_req_pending", {31'd0, mem_rd}, 32'd1);
    mem_en = 1'b1; frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    #1;
    $display("flush: rd=%0b valid=%0b addr=%h", mem_rd, pix_valid, mem_addr);
    check("flush_rd_dropped", {31'd0, mem_rd}, 32'd0);
    check("flush_fifo_empty", {31'd0, pix_valid}, 32'd0);
    check("flush_addr", mem_addr, BASE);

    // ---- fill with no consumption: exactly DEPTH reads ----
    reads = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      #1;
      if (mem_rd && mem_ack) begin
        if (reads == 0) check("fill_first_addr", mem_addr, BASE);
        reads++;
      end
    end
    $display("fill: reads=%0d rd=%0b valid=%0b", reads, mem_rd, pix_valid);
    check("fill_reads", reads, 32'd8);
    check("fill_rd_idle", {31'd0, mem_rd}, 32'd0);

    // ---- consume one word, a new read must follow ----
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      pix_req = 1'b1;
      #1 check($sformatf("pop_byte%0d", b), {24'd0, pix_data}, {24'd0, exp3[b]});
    end
    found = 1'b0; lat_seen = 0;
    for (int i = 1; i <= 3 && !found; i++) begin
      @(negedge clock);
      pix_req = 1'b0;
      #1;
      if (mem_rd) begin found = 1'b1; lat_seen = i; end
    end
    $display("refetch: found=%0b after %0d cycles addr=%h", found, lat_seen, mem_addr);
    check("refetch_found", {31'd0, found}, 32'd1);
    check("refetch_within_2", {31'd0, (lat_seen <= 2)}, 32'd1);
    check("refetch_addr", mem_addr, BASE + 32'h20);

    // ---- reset during a slow request, late ack ignored ----
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0; lat = 5;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clock);
      #1 if (mem_rd) found = 1'b1;
    end
    check("slow_req_seen", {31'd0, found}, 32'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    $display("reset_mid: rd=%0b addr=%h", mem_rd, mem_addr);
    check("rstmid_rd", {31'd0, mem_rd}, 32'd0);
    check("rstmid_addr", mem_addr, BASE);
    @(negedge clock);
    ack_force = 1'b1;
    @(negedge clock);
    ack_force = 1'b0;
    @(negedge clock);
    reset = 1'b1; mem_en = 1'b0; ack_force = 1'b1;
    @(negedge clock);
    ack_force = 1'b0;
    #1;
    $display("late_ack: valid=%0b rd=%0b addr=%h", pix_valid, mem_rd, mem_addr);
    check("late_ack_valid", {31'd0, pix_valid}, 32'd0);
    check("late_ack_rd", {31'd0, mem_rd}, 32'd1);
    check("late_ack_addr", mem_addr, BASE);
    @(negedge clock);
    #1 check("late_ack_valid2", {31'd0, pix_valid}, 32'd0);

    // ---- 3-word frame on the second instance ----
    @(negedge clock);
    fs3 = 1'b1;
    @(negedge clock);
    fs3 = 1'b0; req3 = 1'b1;
    reads = 0; pix_n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rd3) reads++;
      if (req3 && valid3) begin
        if (pix_n < 12)
          check($sformatf("short_pix%0d", pix_n), {24'd0, data3}, {24'd0, exp3[pix_n]});
        pix_n++;
      end
      @(negedge clock);
    end
    #1;
    $display("short_frame: reads=%0d pixels=%0d valid=%0b rd=%0b", reads, pix_n, valid3, rd3);
    check("short_reads", reads, 32'd3);
    check("short_pixels", pix_n, 32'd12);
    check("short_valid_end", {31'd0, valid3}, 32'd0);
    check("short_rd_done", {31'd0, rd3}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
